// File: rtl/bitrev_reorder.sv
// -----------------------------------------------------------------------------
// bitrev_reorder
//
// Converts frames of N = 2**LOGN complex samples arriving in bit-reversed
// (butterfly-output) order into natural order. Two ping-pong banks let one
// frame be written while the previous one is drained. Each bank has a full
// flag. The writer fills a bank linearly, and the reader walks it at
// bit-reversed addresses. Because the reversal is its own inverse, this
// restores natural order.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-low reset
//   in_data    {real, imag} sample, 2*NBITS wide, bit-reversed order
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts in_data this cycle (current write bank not full)
//   out_data   registered {real, imag} sample, natural order
//   out_valid  registered, out_data is valid
//   out_ready  downstream accepts out_data
//   out_last   registered, out_data is sample N-1 of its frame
//
// LOGN must be at least 1.
// -----------------------------------------------------------------------------
module bitrev_reorder #(
    parameter int NBITS = 11,
    parameter int LOGN  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*NBITS-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*NBITS-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);

    localparam int DW = 2 * NBITS;
    localparam int N  = 1 << LOGN;
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } rd_state_e;

    // Two banks of N words each.
    logic [DW-1:0] bank_mem [2][N];

    // Writer state.
    logic [LOGN-1:0] wcnt_q, wcnt_d;
    logic            wbank_q, wbank_d;
    logic [1:0]      full_q, full_d;

    // Reader state.
    rd_state_e       state_q, state_d;
    logic            rbank_q, rbank_d;
    logic [LOGN-1:0] rcnt_q, rcnt_d;

    // Registered output stage.
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    // Handshake and datapath helpers.
    logic            in_fire;
    logic            frame_in_done;
    logic            out_fire;
    logic            frame_out_done;
    logic            other_full;
    logic            rd_bank;
    logic [LOGN-1:0] rd_addr;
    logic [DW-1:0]   rd_word;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = idx[LOGN-1-i];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign in_ready       = ~full_q[wbank_q];
    assign in_fire        = in_valid & in_ready;
    assign frame_in_done  = in_fire & (wcnt_q == LAST_IDX);

    assign out_fire       = out_valid_q & out_ready;
    assign frame_out_done = (state_q == DRAIN) & out_fire & out_last_q;

    // The next bank counts as ready to drain if it is already full, or if its
    // final sample is accepted on this very edge. Chaining straight into it
    // keeps the output gapless when input and output run at full rate. Only
    // address 0 of that bank is read on the chaining edge, and it was written
    // N-1 transfers earlier.
    assign other_full = full_q[~rbank_q] | (frame_in_done & (wbank_q != rbank_q));

    // -------------------------------------------------------------------------
    // Read port: bit-reversed address into the bank being drained. On a frame
    // boundary the first word of the next bank is fetched instead. bitrev(0)
    // is 0.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_bank = rbank_q;
        rd_addr = bitrev(rcnt_q);
        if (frame_out_done) begin
            rd_bank = ~rbank_q;
            rd_addr = '0;
        end
    end

    assign rd_word = bank_mem[rd_bank][rd_addr];

    // -------------------------------------------------------------------------
    // Next-state logic for writer, full flags, read FSM and output stage.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold value first, so that a path that does
        // not assign a signal cannot infer a latch.
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        full_d      = full_q;
        state_d     = state_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        // Writer: linear fill; the counter wraps to 0 after sample N-1.
        if (in_fire) begin
            wcnt_d = wcnt_q + 1'b1;
            if (frame_in_done) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        // Reader. The flag it clears is always the read bank. The writer can
        // only set the other bank's flag in the same cycle, so both updates
        // land.
        case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = DRAIN;
                    rcnt_d  = '0;
                end
            end

            DRAIN: begin
                if (frame_out_done) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    if (other_full) begin
                        out_data_d  = rd_word;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        rcnt_d      = LOGN'(1);
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rcnt_d      = '0;
                        state_d     = IDLE;
                    end
                end else if (!(out_valid_q && out_last_q) && (!out_valid_q || out_ready)) begin
                    // The output register is empty or emptying, and the frame
                    // still has samples to issue.
                    out_data_d  = rd_word;
                    out_valid_d = 1'b1;
                    out_last_d  = (rcnt_q == LAST_IDX);
                    rcnt_d      = rcnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            full_q      <= '0;
            state_q     <= IDLE;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // NOTE: the sample banks have no reset. Cleared full flags already stop
    // stale words from being read, and resetting a RAM array would prevent it
    // from mapping onto memory macros.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            bank_mem[wbank_q][wcnt_q] <= in_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // -------------------------------------------------------------------------
    // Interface contract
    // -------------------------------------------------------------------------
    a_out_hold : assert property (@(posedge clk) disable iff (!rst)
        out_valid_q && !out_ready |=> out_valid_q && $stable(out_data_q) && $stable(out_last_q));

    a_last_valid : assert property (@(posedge clk) disable iff (!rst)
        out_last_q |-> out_valid_q);

endmodule
